// File: rtl/perf_pkg.sv
// perf_pkg: shared FSM state encoding and overflow-mode constants for the perf counter unit
package perf_pkg;
  typedef enum logic [1:0] {STOP = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;
endpackage

// File: rtl/perf_counter_ch.sv
// perf_counter_ch: one event channel with live counter, wrap/saturate, sticky overflow and shadow copy
module perf_counter_ch
  import perf_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             snap_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q;
  logic             ovf_q, ovf_d, full;
  assign full = &cnt_q;
  always_comb begin
    cnt_d = clear_i ? '0 : !en_i ? cnt_q : full ? (SAT == SAT_HOLD ? cnt_q : '0) : cnt_q + 1'b1;
    ovf_d = !clear_i && (ovf_q || (en_i && full));
  end
  // shadow samples the pre-edge count, so snap together with clear keeps the old value
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (snap_i) shadow_q <= cnt_q;
    end
  end
  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;
endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: run/stop/halt FSM controlling N_CH event counters with a registered shadow read port
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int CNT_W = 11,
  parameter int N_CH  = 4,
  parameter int SAT   = SAT_WRAP
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        stop,
  input  logic                                        exc,
  input  logic                                        clear,
  input  logic                                        snap,
  input  logic [N_CH-1:0]                             inc,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0]    rd_sel,
  output logic [CNT_W-1:0]                            rd_data,
  output logic [N_CH-1:0]                             ovf,
  output logic [1:0]                                  state
);
  localparam int SW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int NS = 2 ** SW;
  state_e           state_q, state_d, cur;
  logic             run_en;
  logic [CNT_W-1:0] rd_data_q;
  logic [CNT_W-1:0] shadow [NS];
  // encoding 3 falls back to STOP; edges leaving RUN never count
  always_comb begin
    cur     = (state_q == RUN || state_q == HALT) ? state_q : STOP;
    state_d = clear ? STOP : cur == RUN ? (exc ? HALT : stop ? STOP : RUN) :
              cur == HALT ? HALT : (start && !stop) ? RUN : STOP;
    run_en  = cur == RUN && !(clear || exc || stop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= STOP;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_data_q <= shadow[rd_sel];
    end
  end
  for (genvar i = 0; i < NS; i++) begin : g_ch
    if (i < N_CH) begin : g_on
      perf_counter_ch #(.CNT_W(CNT_W), .SAT(SAT)) u_ch (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .snap_i  (snap),
        .en_i    (run_en && inc[i]),
        .shadow_o(shadow[i]),
        .ovf_o   (ovf[i])
      );
    end else begin : g_off
      assign shadow[i] = '0;
    end
  end
  assign rd_data = rd_data_q;
  assign state   = state_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// tb_perf_counter_unit: table-driven and scoreboard checks of perf_counter_unit in wrap, saturate and 3-channel builds
module tb_perf_counter_unit;
  typedef struct {
    bit rst, sta, sto, exc, clr, snp;
    logic [3:0] inc;
    logic [1:0] sel;
    bit ck;
    logic [3:0] rd;
    logic [1:0] st;
    logic [3:0] ov;
    int inst;
  } vec_t;
  typedef struct {
    int inst;
    logic [3:0] exp;
  } sb_t;
  logic clk = 0, reset = 0, start = 0, stop = 0, exc = 0, clear = 0, snap = 0;
  logic [3:0] inc = 0;
  logic [1:0] rd_sel = 0;
  logic [3:0] rd0, rd1, rd2, ov0, ov1;
  logic [2:0] ov2;
  logic [1:0] st0, st1, st2;
  int total = 0, bad = 0;
  vec_t tbl[$];
  sb_t sbq[$];
  always #5 clk = ~clk;
  perf_counter_unit #(.CNT_W(4), .N_CH(4), .SAT(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .exc(exc), .clear(clear),
    .snap(snap), .inc(inc), .rd_sel(rd_sel), .rd_data(rd0), .ovf(ov0), .state(st0));
  perf_counter_unit #(.CNT_W(4), .N_CH(4), .SAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .exc(exc), .clear(clear),
    .snap(snap), .inc(inc), .rd_sel(rd_sel), .rd_data(rd1), .ovf(ov1), .state(st1));
  perf_counter_unit #(.CNT_W(4), .N_CH(3), .SAT(0)) u2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .exc(exc), .clear(clear),
    .snap(snap), .inc(inc[2:0]), .rd_sel(rd_sel), .rd_data(rd2), .ovf(ov2), .state(st2));
  function automatic logic [3:0] rd_of(int i);
    return i == 0 ? rd0 : i == 1 ? rd1 : rd2;
  endfunction
  function automatic logic [3:0] ov_of(int i);
    return i == 0 ? ov0 : i == 1 ? ov1 : {1'b0, ov2};
  endfunction
  function automatic logic [1:0] st_of(int i);
    return i == 0 ? st0 : i == 1 ? st1 : st2;
  endfunction
  function automatic vec_t mk(bit rst, bit sta, bit sto, bit ex, bit clr, bit snp, logic [3:0] in,
                              logic [1:0] sel, bit ck, logic [3:0] rd, logic [1:0] st,
                              logic [3:0] ov, int inst);
    vec_t v;
    v = '{rst, sta, sto, ex, clr, snp, in, sel, ck, rd, st, ov, inst};
    return v;
  endfunction
  task automatic check(string nm, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic drive(vec_t v);
    reset = v.rst; start = v.sta; stop = v.sto; exc = v.exc;
    clear = v.clr; snap = v.snp; inc = v.inc; rd_sel = v.sel;
    if (v.ck) sbq.push_back('{v.inst, v.rd});
  endtask
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("rd_data inst%0d", e.inst), rd_of(e.inst), e.exp);
    end
  endtask
  task automatic cmd(bit sta, bit sto, bit ex, bit clr, bit snp, logic [3:0] in);
    drive(mk(0, sta, sto, ex, clr, snp, in, 0, 0, 0, 0, 0, 0));
    tick();
  endtask
  task automatic rd_chk(logic [1:0] sel, int inst, logic [3:0] exp);
    drive(mk(0, 0, 0, 0, 0, 0, 0, sel, 1, exp, 0, 0, inst));
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0));
    for (int s = 0; s < 4; s++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 2'(s), 1, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 3, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h4, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 2, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 2, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 4'hF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'h0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 0));
    foreach (tbl[k]) begin
      drive(tbl[k]);
      tick();
      check($sformatf("state row%0d", k), {2'b0, st_of(tbl[k].inst)}, {2'b0, tbl[k].st});
      check($sformatf("ovf row%0d", k), ov_of(tbl[k].inst), tbl[k].ov);
    end
    cmd(0, 0, 0, 1, 0, 0);
    cmd(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cmd(0, 0, 0, 0, 0, 4'h1);
    cmd(0, 1, 0, 0, 0, 0);
    cmd(0, 0, 0, 0, 1, 0);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    sbq.push_back('{1, 4'd15});
    tick();
    check("ovf wrap", ov0, 4'b0001);
    check("ovf sat", ov1, 4'b0001);
    cmd(0, 0, 0, 1, 0, 0);
    cmd(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cmd(0, 0, 0, 0, 0, 4'h2);
    cmd(0, 1, 1, 0, 0, 4'h2);
    check("state halt", {2'b0, st0}, 4'd2);
    cmd(1, 0, 0, 0, 0, 4'h2);
    check("state halt after start", {2'b0, st0}, 4'd2);
    cmd(0, 0, 0, 0, 0, 4'h2);
    cmd(0, 0, 0, 0, 1, 0);
    rd_chk(1, 0, 3);
    cmd(0, 0, 0, 1, 0, 0);
    check("state after clear", {2'b0, st0}, 4'd0);
    cmd(0, 0, 0, 0, 1, 0);
    rd_chk(1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
